// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read arbiter slice.
//   - AXI burst type codes
//   - arbiter FSM state encoding
//   - master index width (two masters -> one bit)
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam int MIDX_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin pick, purely combinational.
//   req  : request vector, bit x = master x
//   prio : master that wins when both request
//   gnt  : one-hot winner, or zero when nobody requests
// The priority pointer itself is kept and updated by the parent.
module rr_arb2
    import axi_pkg::*;
(
    input  logic [1:0]        req,
    input  logic [MIDX_W-1:0] prio,
    output logic [1:0]        gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = prio ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master / one-slave AXI read arbiter.
// One complete burst is granted at a time, round-robin between M0 and M1.
// The winning AR payload is registered and presented to the slave; R beats are
// passed through combinationally to the granted master until the RLAST beat.
// Ports:
//   ACLK, ARESET            clock, synchronous active-high reset
//   M0_*/M1_*               AR request and R response per master
//   S_*                     AR request and R response toward the slave
//   S_ARLOCK/CACHE/PROT     tied to zero
//   err                     sticky flag: RLAST did not line up with ARLEN
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter int BusWidth = 32,
    parameter int TagBits  = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    // master 0
    input  logic [TagBits-1:0]  M0_ARID,
    input  logic [BusWidth-1:0] M0_ARADDR,
    input  logic [3:0]          M0_ARLEN,
    input  logic [1:0]          M0_ARSIZE,
    input  logic [1:0]          M0_ARBURST,
    input  logic                M0_ARVALID,
    output logic                M0_ARREADY,
    output logic [TagBits-1:0]  M0_RID,
    output logic [BusWidth-1:0] M0_RDATA,
    output logic [1:0]          M0_RRESP,
    output logic                M0_RLAST,
    output logic                M0_RVALID,
    input  logic                M0_RREADY,
    // master 1
    input  logic [TagBits-1:0]  M1_ARID,
    input  logic [BusWidth-1:0] M1_ARADDR,
    input  logic [3:0]          M1_ARLEN,
    input  logic [1:0]          M1_ARSIZE,
    input  logic [1:0]          M1_ARBURST,
    input  logic                M1_ARVALID,
    output logic                M1_ARREADY,
    output logic [TagBits-1:0]  M1_RID,
    output logic [BusWidth-1:0] M1_RDATA,
    output logic [1:0]          M1_RRESP,
    output logic                M1_RLAST,
    output logic                M1_RVALID,
    input  logic                M1_RREADY,
    // slave
    output logic [TagBits-1:0]  S_ARID,
    output logic [BusWidth-1:0] S_ARADDR,
    output logic [3:0]          S_ARLEN,
    output logic [1:0]          S_ARSIZE,
    output logic [1:0]          S_ARBURST,
    output logic                S_ARLOCK,
    output logic [3:0]          S_ARCACHE,
    output logic [2:0]          S_ARPROT,
    output logic                S_ARVALID,
    input  logic                S_ARREADY,
    input  logic [TagBits-1:0]  S_RID,
    input  logic [BusWidth-1:0] S_RDATA,
    input  logic [1:0]          S_RRESP,
    input  logic                S_RLAST,
    input  logic                S_RVALID,
    output logic                S_RREADY,
    output logic                err
);

    state_t              state;
    logic [MIDX_W-1:0]   grant;
    logic [MIDX_W-1:0]   prio;
    logic [1:0]          beats;
    logic [1:0]          len_q;
    logic [1:0]          gnt;
    logic                in_idle, in_data, r_hs;

    logic [TagBits-1:0]  win_id;
    logic [BusWidth-1:0] win_addr;
    logic [3:0]          win_len;
    logic [1:0]          win_size;
    logic [1:0]          win_burst;

    rr_arb2 u_arb (
        .req  ({M1_ARVALID, M0_ARVALID}),
        .prio (prio),
        .gnt  (gnt)
    );

    assign in_idle = (state == ST_IDLE);
    assign in_data = (state == ST_DATA);

    // ARREADY is held low during reset so a master cannot see a handshake
    // that the reset is about to discard.
    assign M0_ARREADY = in_idle & gnt[0] & ~ARESET;
    assign M1_ARREADY = in_idle & gnt[1] & ~ARESET;

    always_comb begin
        if (gnt[1]) begin
            win_id    = M1_ARID;
            win_addr  = M1_ARADDR;
            win_len   = M1_ARLEN;
            win_size  = M1_ARSIZE;
            win_burst = M1_ARBURST;
        end else begin
            win_id    = M0_ARID;
            win_addr  = M0_ARADDR;
            win_len   = M0_ARLEN;
            win_size  = M0_ARSIZE;
            win_burst = M0_ARBURST;
        end
    end

    assign S_ARVALID = (state == ST_ADDR);
    assign S_ARLOCK  = 1'b0;
    assign S_ARCACHE = 4'd0;
    assign S_ARPROT  = 3'd0;

    // R channel: payload fans out to both masters, only the handshake
    // signals are steered by grant. Outside DATA the slave sees no ready.
    assign S_RREADY  = in_data & (grant[0] ? M1_RREADY : M0_RREADY);
    assign M0_RVALID = in_data & S_RVALID & ~grant[0];
    assign M1_RVALID = in_data & S_RVALID &  grant[0];
    assign r_hs      = in_data & S_RVALID & S_RREADY;

    assign M0_RID   = S_RID;
    assign M0_RDATA = S_RDATA;
    assign M0_RRESP = S_RRESP;
    assign M0_RLAST = S_RLAST;
    assign M1_RID   = S_RID;
    assign M1_RDATA = S_RDATA;
    assign M1_RRESP = S_RRESP;
    assign M1_RLAST = S_RLAST;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            grant     <= '0;
            prio      <= '0;
            beats     <= 2'd0;
            len_q     <= 2'd0;
            err       <= 1'b0;
            S_ARID    <= '0;
            S_ARADDR  <= '0;
            S_ARLEN   <= 4'd0;
            S_ARSIZE  <= 2'd0;
            S_ARBURST <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        S_ARID    <= win_id;
                        S_ARADDR  <= win_addr;
                        S_ARLEN   <= win_len;
                        S_ARSIZE  <= win_size;
                        S_ARBURST <= win_burst;
                        grant     <= gnt[1];
                        beats     <= 2'd0;
                        // slave caps bursts at 4 beats, upper length bits unused
                        len_q     <= win_len[1:0];
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (S_ARREADY)
                        state <= ST_DATA;
                end
                ST_DATA: begin
                    if (r_hs) begin
                        beats <= beats + 2'd1;
                        if (S_RLAST) begin
                            state <= ST_IDLE;
                            prio  <= ~grant;
                            if (beats != len_q)
                                err <= 1'b1;
                        end else if (beats == len_q) begin
                            // expected last beat arrived without RLAST
                            err <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;
    import axi_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  M0_ARID, M1_ARID, M0_RID, M1_RID, S_ARID, S_RID;
    logic [31:0] M0_ARADDR, M1_ARADDR, M0_RDATA, M1_RDATA, S_ARADDR, S_RDATA;
    logic [3:0]  M0_ARLEN, M1_ARLEN, S_ARLEN, S_ARCACHE;
    logic [1:0]  M0_ARSIZE, M1_ARSIZE, S_ARSIZE, M0_ARBURST, M1_ARBURST, S_ARBURST;
    logic [1:0]  M0_RRESP, M1_RRESP, S_RRESP;
    logic        M0_ARVALID, M1_ARVALID, M0_ARREADY, M1_ARREADY;
    logic        M0_RLAST, M1_RLAST, S_RLAST, M0_RVALID, M1_RVALID, S_RVALID;
    logic        M0_RREADY, M1_RREADY, S_RREADY, S_ARVALID, S_ARREADY, S_ARLOCK;
    logic [2:0]  S_ARPROT;
    logic        err;

    always #5 ACLK = ~ACLK;

    axi_read_arbiter #(.BusWidth(32), .TagBits(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .M0_ARID(M0_ARID), .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN),
        .M0_ARSIZE(M0_ARSIZE), .M0_ARBURST(M0_ARBURST), .M0_ARVALID(M0_ARVALID),
        .M0_ARREADY(M0_ARREADY), .M0_RID(M0_RID), .M0_RDATA(M0_RDATA),
        .M0_RRESP(M0_RRESP), .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID),
        .M0_RREADY(M0_RREADY),
        .M1_ARID(M1_ARID), .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN),
        .M1_ARSIZE(M1_ARSIZE), .M1_ARBURST(M1_ARBURST), .M1_ARVALID(M1_ARVALID),
        .M1_ARREADY(M1_ARREADY), .M1_RID(M1_RID), .M1_RDATA(M1_RDATA),
        .M1_RRESP(M1_RRESP), .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID),
        .M1_RREADY(M1_RREADY),
        .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
        .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST), .S_ARLOCK(S_ARLOCK),
        .S_ARCACHE(S_ARCACHE), .S_ARPROT(S_ARPROT), .S_ARVALID(S_ARVALID),
        .S_ARREADY(S_ARREADY), .S_RID(S_RID), .S_RDATA(S_RDATA),
        .S_RRESP(S_RRESP), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID),
        .S_RREADY(S_RREADY), .err(err)
    );

    // in : {rst, m0_arvalid, m1_arvalid, s_arready, s_rvalid, s_rlast, m0_rready, m1_rready}
    // exp: {m0_arready, m1_arready, s_arvalid, s_rready, m0_rvalid, m1_rvalid, err}
    // addr: expected S_ARADDR whenever s_arvalid is expected
    typedef struct {
        logic [7:0]  in;
        logic [6:0]  exp;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad   = 0;

    task automatic add(input logic [7:0] in, input logic [6:0] exp, input logic [31:0] addr);
        vec_t v;
        v.in = in; v.exp = exp; v.addr = addr;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    initial begin
        // M0: 4-beat INCR at 0x100; M1: ARLEN=5 (upper bits ignored -> 2 beats) at 0x200
        M0_ARID = 4'h5; M0_ARADDR = 32'h100; M0_ARLEN = 4'd3; M0_ARSIZE = 2'd2; M0_ARBURST = BURST_INCR;
        M1_ARID = 4'h9; M1_ARADDR = 32'h200; M1_ARLEN = 4'd5; M1_ARSIZE = 2'd2; M1_ARBURST = BURST_WRAP;
        ARESET = 1'b1; M0_ARVALID = 0; M1_ARVALID = 0; S_ARREADY = 0;
        S_RVALID = 0; S_RLAST = 0; M0_RREADY = 0; M1_RREADY = 0;
        S_RID = 4'h0; S_RDATA = 32'h0; S_RRESP = 2'b00;

        // M0 alone, 4 beats, a gap in S_RVALID, RVALID ignored in IDLE
        add(8'b0100_0000, 7'b1000000, 32'h0);
        add(8'b0000_0000, 7'b0010000, 32'h100);
        add(8'b0001_0000, 7'b0010000, 32'h100);
        add(8'b0000_1010, 7'b0001100, 32'h0);
        add(8'b0000_1010, 7'b0001100, 32'h0);
        add(8'b0000_0010, 7'b0001000, 32'h0);
        add(8'b0000_1010, 7'b0001100, 32'h0);
        add(8'b0000_1110, 7'b0001100, 32'h0);
        add(8'b0000_1010, 7'b0000000, 32'h0);
        // reset, then both request: M0 first, M1 right after M0's RLAST
        add(8'b1000_0000, 7'b0000000, 32'h0);
        add(8'b0110_0000, 7'b1000000, 32'h0);
        add(8'b0011_0000, 7'b0010000, 32'h100);
        add(8'b0010_1011, 7'b0001100, 32'h0);
        add(8'b0010_1011, 7'b0001100, 32'h0);
        add(8'b0010_1011, 7'b0001100, 32'h0);
        add(8'b0010_1111, 7'b0001100, 32'h0);
        add(8'b0010_0000, 7'b0100000, 32'h0);
        add(8'b0001_0000, 7'b0010000, 32'h200);
        // M1 stalls 3 cycles with S_RVALID high
        add(8'b0000_1010, 7'b0000010, 32'h0);
        add(8'b0000_1010, 7'b0000010, 32'h0);
        add(8'b0000_1010, 7'b0000010, 32'h0);
        add(8'b0000_1001, 7'b0001010, 32'h0);
        add(8'b0000_1101, 7'b0001010, 32'h0);
        // both again: pointer is back on M0
        add(8'b0110_0000, 7'b1000000, 32'h0);
        add(8'b0011_0000, 7'b0010000, 32'h100);
        add(8'b0010_1010, 7'b0001100, 32'h0);
        add(8'b0010_1010, 7'b0001100, 32'h0);
        add(8'b0010_1010, 7'b0001100, 32'h0);
        add(8'b0010_1110, 7'b0001100, 32'h0);
        // M1 expects 2 beats, slave ends after 1 -> err, sticky across good burst
        add(8'b0010_0000, 7'b0100000, 32'h0);
        add(8'b0001_0000, 7'b0010000, 32'h200);
        add(8'b0000_1101, 7'b0001010, 32'h0);
        add(8'b0000_0000, 7'b0000001, 32'h0);
        add(8'b0100_0000, 7'b1000001, 32'h0);
        add(8'b0001_0000, 7'b0010001, 32'h100);
        add(8'b0000_1010, 7'b0001101, 32'h0);
        add(8'b0000_1010, 7'b0001101, 32'h0);
        add(8'b0000_1010, 7'b0001101, 32'h0);
        add(8'b0000_1110, 7'b0001101, 32'h0);
        // reset in the middle of a DATA phase
        add(8'b0100_0000, 7'b1000001, 32'h0);
        add(8'b0001_0000, 7'b0010001, 32'h100);
        add(8'b0000_1010, 7'b0001101, 32'h0);
        add(8'b1000_1010, 7'b0001101, 32'h0);
        add(8'b0000_1011, 7'b0000000, 32'h0);
        add(8'b0110_0000, 7'b1000000, 32'h0);
        // reset again in ADDR, then a plain M1 burst
        add(8'b1010_0000, 7'b0010000, 32'h100);
        add(8'b0010_0000, 7'b0100000, 32'h0);
        add(8'b0001_0000, 7'b0010000, 32'h200);
        add(8'b0000_1001, 7'b0001010, 32'h0);
        add(8'b0000_1101, 7'b0001010, 32'h0);
        add(8'b0000_0000, 7'b0000000, 32'h0);

        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        #2;
        chk("reset_outputs", {57'd0, M0_ARREADY, M1_ARREADY, S_ARVALID, S_RREADY, M0_RVALID, M1_RVALID, err}, 64'd0);
        chk("reset_payload", {S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST}, 64'd0);
        chk("tied_side", {S_ARLOCK, S_ARCACHE, S_ARPROT}, 64'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge ACLK);
            {ARESET, M0_ARVALID, M1_ARVALID, S_ARREADY, S_RVALID, S_RLAST, M0_RREADY, M1_RREADY} = tbl[i].in;
            S_RDATA = $urandom;
            S_RID   = 4'($urandom);
            S_RRESP = 2'($urandom);
            #2;
            chk($sformatf("vec%0d_ctl", i),
                {57'd0, M0_ARREADY, M1_ARREADY, S_ARVALID, S_RREADY, M0_RVALID, M1_RVALID, err},
                {57'd0, tbl[i].exp});
            if (tbl[i].exp[4]) begin
                if (tbl[i].addr == 32'h100)
                    chk($sformatf("vec%0d_ar", i), {S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST},
                        {4'h5, 32'h100, 4'd3, 2'd2, BURST_INCR});
                else
                    chk($sformatf("vec%0d_ar", i), {S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST},
                        {4'h9, 32'h200, 4'd5, 2'd2, BURST_WRAP});
            end
            if (i % 8 == 3)
                chk($sformatf("vec%0d_rpath", i),
                    {M0_RDATA, M1_RID, M0_RRESP, M1_RLAST, M0_RLAST, 23'd0},
                    {S_RDATA, S_RID, S_RRESP, S_RLAST, S_RLAST, 23'd0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
